// File: rtl/tsn_cbs_multiq_shaper_pkg.sv
// Shared definitions for the multi-queue credit-based shaper: FSM encoding,
// default parameter values and two's-complement saturation bounds.
package tsn_cbs_multiq_shaper_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TX   = 1'b1
  } cbs_state_t;

  localparam int DEF_QUEUE_NUM = 8;
  localparam int DEF_CREDIT_W  = 16;
  localparam int DEF_SLOPE_W   = 8;
  localparam int QID_W         = 4;

  // Most positive / most negative value of a w-bit signed credit.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/tsn_cbs_credit_cell.sv
// One queue's shaping state: stored slopes/enable, the saturating credit
// register and the registered eligibility bit.
module tsn_cbs_credit_cell
  import tsn_cbs_multiq_shaper_pkg::*;
#(
  parameter int CREDIT_W = DEF_CREDIT_W,
  parameter int SLOPE_W  = DEF_SLOPE_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cfg_wr,
  input  logic [SLOPE_W-1:0]         i_cfg_idleslope,
  input  logic [SLOPE_W-1:0]         i_cfg_sendslope,
  input  logic                       i_cfg_cbs_en,
  input  logic signed [CREDIT_W:0]   i_ceiling,
  input  logic                       i_empty,
  input  logic                       i_tx_sel,
  input  logic                       i_tx_valid,
  output logic signed [CREDIT_W-1:0] o_credit,
  output logic                       o_eligible
);

  localparam logic signed [CREDIT_W:0] C_MIN = (CREDIT_W+1)'(sat_min(CREDIT_W));

  logic [SLOPE_W-1:0]         r_idleslope;
  logic [SLOPE_W-1:0]         r_sendslope;
  logic                       r_cbs_en;
  logic signed [CREDIT_W-1:0] r_credit;
  logic                       r_eligible;

  logic signed [CREDIT_W:0]   w_ext;
  logic signed [CREDIT_W:0]   w_up;
  logic signed [CREDIT_W:0]   w_dn;
  logic signed [CREDIT_W-1:0] w_next;

  // One extra bit of headroom lets a single add/subtract overflow be caught.
  assign w_ext = {r_credit[CREDIT_W-1], r_credit};
  assign w_up  = w_ext + $signed({{(CREDIT_W+1-SLOPE_W){1'b0}}, r_idleslope});
  assign w_dn  = w_ext - $signed({{(CREDIT_W+1-SLOPE_W){1'b0}}, r_sendslope});

  always_comb begin
    // NOTE: default first, so no branch can leave w_next unassigned (no latch).
    w_next = r_credit;
    if (!r_cbs_en) begin
      w_next = '0;
    end else if (i_tx_sel && i_tx_valid) begin
      w_next = (w_dn < C_MIN) ? C_MIN[CREDIT_W-1:0] : w_dn[CREDIT_W-1:0];
    end else if (i_tx_sel) begin
      w_next = r_credit;
    end else if (!i_empty || (r_credit < 0)) begin
      w_next = (w_up > i_ceiling) ? i_ceiling[CREDIT_W-1:0] : w_up[CREDIT_W-1:0];
    end else if (r_credit > 0) begin
      w_next = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: slopes and enable are reset with the credit, so a queue never shapes on stale config.
      r_idleslope <= '0;
      r_sendslope <= '0;
      r_cbs_en    <= 1'b0;
      r_credit    <= '0;
      r_eligible  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every read in this cycle sees pre-edge state.
      if (i_cfg_wr) begin
        r_idleslope <= i_cfg_idleslope;
        r_sendslope <= i_cfg_sendslope;
        r_cbs_en    <= i_cfg_cbs_en;
      end
      r_credit   <= w_next;
      r_eligible <= ~i_empty & (~r_cbs_en | ~r_credit[CREDIT_W-1]);
    end
  end

  assign o_credit   = r_credit;
  assign o_eligible = r_eligible;

endmodule

// File: rtl/tsn_cbs_multiq_shaper.sv
// Multi-queue 802.1Qav credit-based shaper: grant FSM plus one credit cell per
// queue. Define TSN_CBS_HICREDIT_EN to clamp positive credit to i_hicredit.
module tsn_cbs_multiq_shaper
  import tsn_cbs_multiq_shaper_pkg::*;
#(
  parameter int QUEUE_NUM = DEF_QUEUE_NUM,
  parameter int CREDIT_W  = DEF_CREDIT_W,
  parameter int SLOPE_W   = DEF_SLOPE_W
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_cfg_wr,
  input  logic [QID_W-1:0]              i_cfg_qid,
  input  logic [SLOPE_W-1:0]            i_cfg_idleslope,
  input  logic [SLOPE_W-1:0]            i_cfg_sendslope,
  input  logic                          i_cfg_cbs_en,
  input  logic [CREDIT_W-1:0]           i_hicredit,
  input  logic [QUEUE_NUM-1:0]          i_fifoc_empty,
  input  logic [QUEUE_NUM-1:0]          i_scheduing_rst,
  input  logic                          i_scheduing_rst_vld,
  input  logic                          i_pmac_tx_axis_valid,
  input  logic                          i_pmac_tx_axis_last,
  output logic [QUEUE_NUM-1:0]          o_queue,
  output logic                          o_queue_vld,
  output logic                          o_sched_err,
  output logic [QUEUE_NUM*CREDIT_W-1:0] o_credit_bus
);

  cbs_state_t               r_state;
  logic [QID_W-1:0]         r_tx_q;
  logic                     r_queue_vld;
  logic                     r_sched_err;
  logic [QID_W-1:0]         w_grant_idx;
  logic signed [CREDIT_W:0] w_ceiling;

`ifdef TSN_CBS_HICREDIT_EN
  // A non-positive ceiling degenerates to zero: the queue can never bank credit.
  assign w_ceiling = i_hicredit[CREDIT_W-1] ? '0 : {1'b0, i_hicredit};
`else
  localparam logic signed [CREDIT_W:0] C_MAX = (CREDIT_W+1)'(sat_max(CREDIT_W));
  logic w_unused_hicredit;
  assign w_ceiling         = C_MAX;
  assign w_unused_hicredit = ^i_hicredit;
`endif

  always_comb begin
    w_grant_idx = '0;
    for (int q = 0; q < QUEUE_NUM; q++) begin
      if (i_scheduing_rst[q]) w_grant_idx = QID_W'(q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_tx_q      <= '0;
      r_queue_vld <= 1'b0;
      r_sched_err <= 1'b0;
    end else begin
      r_queue_vld <= 1'b1;
      r_sched_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_scheduing_rst_vld) begin
            if ($onehot(i_scheduing_rst)) begin
              r_state <= ST_TX;
              r_tx_q  <= w_grant_idx;
            end else begin
              r_sched_err <= 1'b1;
            end
          end
        end
        ST_TX: begin
          if (i_pmac_tx_axis_valid && i_pmac_tx_axis_last) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar q = 0; q < QUEUE_NUM; q++) begin : g_cell
    logic w_cfg_hit;
    logic w_tx_sel;
    // Out-of-range queue ids match no cell and are dropped.
    assign w_cfg_hit = i_cfg_wr && (i_cfg_qid == QID_W'(q));
    assign w_tx_sel  = (r_state == ST_TX) && (r_tx_q == QID_W'(q));

    tsn_cbs_credit_cell #(
      .CREDIT_W (CREDIT_W),
      .SLOPE_W  (SLOPE_W)
    ) u_cell (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_cfg_wr        (w_cfg_hit),
      .i_cfg_idleslope (i_cfg_idleslope),
      .i_cfg_sendslope (i_cfg_sendslope),
      .i_cfg_cbs_en    (i_cfg_cbs_en),
      .i_ceiling       (w_ceiling),
      .i_empty         (i_fifoc_empty[q]),
      .i_tx_sel        (w_tx_sel),
      .i_tx_valid      (i_pmac_tx_axis_valid),
      .o_credit        (o_credit_bus[q*CREDIT_W +: CREDIT_W]),
      .o_eligible      (o_queue[q])
    );
  end

  assign o_queue_vld = r_queue_vld;
  assign o_sched_err = r_sched_err;

endmodule

// File: tb/tb_tsn_cbs_multiq_shaper.sv
// Scoreboard bench for tsn_cbs_multiq_shaper: expectations are queued as each
// cycle's stimulus is driven and compared after the following clock edge.
module tb_tsn_cbs_multiq_shaper;

  localparam int QN = 8;
  localparam int CW = 16;
  localparam int SW = 8;
`ifdef TSN_CBS_HICREDIT_EN
  localparam int CEIL = 100;
`else
  localparam int CEIL = 32767;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_wr;
  logic [3:0]        cfg_qid;
  logic [SW-1:0]     cfg_idle;
  logic [SW-1:0]     cfg_send;
  logic              cfg_en;
  logic [CW-1:0]     hicredit;
  logic [QN-1:0]     fifo_empty;
  logic [QN-1:0]     grant;
  logic              grant_vld;
  logic              tx_valid;
  logic              tx_last;
  logic [QN-1:0]     queue;
  logic              queue_vld;
  logic              sched_err;
  logic [QN*CW-1:0]  credit_bus;

  always #5 clk = ~clk;

  tsn_cbs_multiq_shaper #(.QUEUE_NUM(QN), .CREDIT_W(CW), .SLOPE_W(SW)) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_cfg_wr             (cfg_wr),
    .i_cfg_qid            (cfg_qid),
    .i_cfg_idleslope      (cfg_idle),
    .i_cfg_sendslope      (cfg_send),
    .i_cfg_cbs_en         (cfg_en),
    .i_hicredit           (hicredit),
    .i_fifoc_empty        (fifo_empty),
    .i_scheduing_rst      (grant),
    .i_scheduing_rst_vld  (grant_vld),
    .i_pmac_tx_axis_valid (tx_valid),
    .i_pmac_tx_axis_last  (tx_last),
    .o_queue              (queue),
    .o_queue_vld          (queue_vld),
    .o_sched_err          (sched_err),
    .o_credit_bus         (credit_bus)
  );

  typedef enum int {K_CREDIT, K_QBIT, K_QALL, K_VLD, K_ERR} kind_e;
  typedef struct {
    string tag;
    kind_e kind;
    int    idx;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] observe(input kind_e k, input int idx);
    logic signed [CW-1:0] c;
    case (k)
      K_CREDIT: begin
        c = credit_bus[idx*CW +: CW];
        return c;
      end
      K_QBIT:  return {31'd0, queue[idx]};
      K_QALL:  return {24'd0, queue};
      K_VLD:   return {31'd0, queue_vld};
      default: return {31'd0, sched_err};
    endcase
  endfunction

  function automatic void push_exp(input string tag, input kind_e k, input int idx,
                                   input int exp);
    exp_t e;
    e.tag  = tag;
    e.kind = k;
    e.idx  = idx;
    e.exp  = exp;
    sb.push_back(e);
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.kind, e.idx), e.exp);
    end
  endtask

  task automatic cfg(input int qid, input int idle, input int send, input logic en);
    cfg_wr   = 1'b1;
    cfg_qid  = 4'(qid);
    cfg_idle = SW'(idle);
    cfg_send = SW'(send);
    cfg_en   = en;
    tick();
    cfg_wr   = 1'b0;
  endtask

  task automatic push_reset_state(input string pfx);
    for (int q = 0; q < QN; q++) push_exp($sformatf("%s_credit%0d", pfx, q), K_CREDIT, q, 0);
    push_exp({pfx, "_queue"}, K_QALL, 0, 0);
    push_exp({pfx, "_vld"}, K_VLD, 0, 0);
    push_exp({pfx, "_err"}, K_ERR, 0, 0);
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; cfg_qid = '0; cfg_idle = '0; cfg_send = '0; cfg_en = 1'b0;
    hicredit = CW'(100); fifo_empty = '1; grant = '0; grant_vld = 1'b0;
    tx_valid = 1'b0; tx_last = 1'b0;

    tick();
    push_reset_state("reset");
    tick();
    rst = 1'b0;
    push_exp("vld_after_reset", K_VLD, 0, 1);
    tick();

    // Basic frame on q2: grant while empty so the start credit stays 0.
    cfg(2, 4, 12, 1'b1);
    grant = 8'b0000_0100; grant_vld = 1'b1;
    push_exp("s1_grant_credit", K_CREDIT, 2, 0);
    push_exp("s1_grant_err", K_ERR, 0, 0);
    tick();
    grant_vld = 1'b0; grant = '0;
    fifo_empty[2] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tx_valid = 1'b1; tx_last = (k == 5);
      push_exp($sformatf("s1_beat%0d_credit", k), K_CREDIT, 2, -12 * k);
      push_exp($sformatf("s1_beat%0d_queue", k), K_QBIT, 2, int'(k == 1));
      tick();
    end
    tx_valid = 1'b0; tx_last = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 10) begin
        cfg_wr = 1'b1; cfg_qid = 4'd2; cfg_idle = 8'd4; cfg_send = 8'd12; cfg_en = 1'b1;
      end
      push_exp($sformatf("s1_recover%0d_credit", k), K_CREDIT, 2, -60 + 4 * k);
      push_exp($sformatf("s1_recover%0d_queue", k), K_QBIT, 2, int'(k >= 16));
      tick();
      cfg_wr = 1'b0;
    end

    // Positive credit is discarded once the FIFO drains.
    fifo_empty[2] = 1'b1;
    push_exp("s2_drain_credit", K_CREDIT, 2, 0);
    push_exp("s2_drain_queue", K_QBIT, 2, 0);
    tick();
    push_exp("s2_hold_credit", K_CREDIT, 2, 0);
    tick();

    // Out-of-range config id must not alias onto q0.
    cfg(8, 5, 5, 1'b1);
    fifo_empty[0] = 1'b0;
    push_exp("qid8_credit0_a", K_CREDIT, 0, 0);
    push_exp("qid8_queue0_a", K_QBIT, 0, 1);
    tick();
    push_exp("qid8_credit0_b", K_CREDIT, 0, 0);
    tick();
    fifo_empty[0] = 1'b1;

    // Illegal grants in IDLE: error pulse, FSM stays IDLE (beat ignored).
    grant = 8'b0000_0110; grant_vld = 1'b1;
    push_exp("multihot_err", K_ERR, 0, 1);
    tick();
    grant_vld = 1'b0; grant = '0; tx_valid = 1'b1;
    push_exp("multihot_err_clear", K_ERR, 0, 0);
    push_exp("multihot_idle_credit2", K_CREDIT, 2, 0);
    tick();
    tx_valid = 1'b0;
    grant_vld = 1'b1;
    push_exp("zero_grant_err", K_ERR, 0, 1);
    tick();
    grant_vld = 1'b0;
    push_exp("zero_grant_err_clear", K_ERR, 0, 0);
    tick();

    // Grant during TX is ignored.
    cfg(3, 4, 12, 1'b1);
    grant = 8'b0000_0100; grant_vld = 1'b1;
    push_exp("s4_grant_err", K_ERR, 0, 0);
    tick();
    grant = 8'b0000_1000;
    push_exp("s4_regrant_err", K_ERR, 0, 0);
    push_exp("s4_regrant_credit2", K_CREDIT, 2, 0);
    push_exp("s4_regrant_credit3", K_CREDIT, 3, 0);
    tick();
    grant_vld = 1'b0; grant = '0; tx_valid = 1'b1; tx_last = 1'b1;
    push_exp("s4_last_credit2", K_CREDIT, 2, -12);
    push_exp("s4_last_credit3", K_CREDIT, 3, 0);
    push_exp("s4_last_err", K_ERR, 0, 0);
    tick();
    tx_valid = 1'b0; tx_last = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      push_exp($sformatf("s4_neg_recover%0d", k), K_CREDIT, 2, -12 + 4 * k);
      tick();
    end

    // Positive ceiling.
    cfg(4, 30, 12, 1'b1);
    fifo_empty[4] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      push_exp($sformatf("ceil30_k%0d", k), K_CREDIT, 4, min_i(30 * k, CEIL));
      tick();
    end
    fifo_empty[4] = 1'b1;
    push_exp("ceil30_drain", K_CREDIT, 4, 0);
    tick();
    cfg(5, 255, 0, 1'b1);
    fifo_empty[5] = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      push_exp($sformatf("ceil255_k%0d", k), K_CREDIT, 5, min_i(255 * k, CEIL));
      tick();
    end
    fifo_empty[5] = 1'b1;
    tick();
`ifdef TSN_CBS_HICREDIT_EN
    hicredit = CW'(-5);
    cfg(7, 10, 0, 1'b1);
    fifo_empty[7] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      push_exp($sformatf("neg_hicredit_k%0d", k), K_CREDIT, 7, 0);
      tick();
    end
    fifo_empty[7] = 1'b1;
    hicredit = CW'(100);
`endif

    // Negative saturation on a long frame.
    cfg(6, 0, 255, 1'b1);
    grant = 8'b0100_0000; grant_vld = 1'b1;
    tick();
    grant_vld = 1'b0; grant = '0;
    for (int k = 1; k <= 130; k++) begin
      tx_valid = 1'b1; tx_last = (k == 130);
      push_exp($sformatf("floor_k%0d", k), K_CREDIT, 6, max_i(-255 * k, -32768));
      tick();
    end
    tx_valid = 1'b0; tx_last = 1'b0;
    push_exp("floor_hold", K_CREDIT, 6, -32768);
    tick();
    cfg(6, 0, 0, 1'b0);
    push_exp("disable_forces_zero", K_CREDIT, 6, 0);
    tick();

    // Reset in the middle of a frame.
    grant = 8'b0000_0100; grant_vld = 1'b1;
    push_exp("s6_grant_credit2", K_CREDIT, 2, 0);
    tick();
    grant_vld = 1'b0; grant = '0;
    for (int k = 1; k <= 2; k++) begin
      tx_valid = 1'b1;
      push_exp($sformatf("s6_beat%0d", k), K_CREDIT, 2, -12 * k);
      tick();
    end
    rst = 1'b1;
    push_reset_state("midframe_reset");
    tick();
    rst = 1'b0;
    cfg_wr = 1'b1; cfg_qid = 4'd2; cfg_idle = 8'd4; cfg_send = 8'd12; cfg_en = 1'b1;
    push_exp("s6_vld_back", K_VLD, 0, 1);
    push_exp("s6_stale_beat4", K_CREDIT, 2, 0);
    tick();
    cfg_wr = 1'b0; tx_last = 1'b1;
    push_exp("s6_stale_last", K_CREDIT, 2, 0);
    tick();
    tx_valid = 1'b0; tx_last = 1'b0;
    grant = 8'b0000_0100; grant_vld = 1'b1;
    tick();
    grant_vld = 1'b0; grant = '0; tx_valid = 1'b1; tx_last = 1'b1;
    push_exp("s6_new_frame", K_CREDIT, 2, -12);
    tick();
    tx_valid = 1'b0; tx_last = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
